// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one sram-like memory port between the I-cache and
// the D-cache, one transaction outstanding at a time.
// Optional feature: define CACHE_ARB_ROUND_ROBIN_EN to alternate grants on ties;
// otherwise the D-cache always wins ties.
//
// state | meaning
// IDLE  | no transaction; arbitrate among requesters
// ADDR  | owner's request forwarded, waiting for m_addr_ok
// DATA  | address accepted, waiting for m_data_ok
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic                  i_wr,
    input  logic [1:0]            i_size,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_addr_ok,
    output logic                  i_data_ok,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [1:0]            d_size,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_addr_ok,
    output logic                  d_data_ok,
    output logic                  m_req,
    output logic                  m_wr,
    output logic [1:0]            m_size,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_addr_ok,
    input  logic                  m_data_ok
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_owner;        // 0 = I-cache, 1 = D-cache
    logic   w_owner_nxt;
    logic   w_grant;
    logic   w_owner_req;
    logic   w_fwd;
    logic   w_addr_ok;
    logic   w_data_ok;
    logic   w_done;

    assign w_owner_req = r_owner ? d_req : i_req;
    // A dropped request in ADDR is a protocol error: nothing is forwarded so
    // the bridge never sees a half-withdrawn transaction.
    assign w_fwd = (r_state == ADDR) && w_owner_req;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    logic r_last_owner;

    // Tie goes to whichever cache was not served last.
    always_comb begin
        w_grant = d_req;
        if (i_req && d_req)
            w_grant = ~r_last_owner;
    end

    // Remember the owner of the last completed transaction.
    always_ff @(posedge clk) begin
        if (rst)
            r_last_owner <= 1'b0;
        else if (w_done)
            r_last_owner <= r_owner;
    end
`else
    // Fixed priority: D-cache wins whenever it is requesting.
    always_comb begin
        w_grant = d_req;
    end
`endif

    // State and owner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Next-state logic and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_addr_ok   = 1'b0;
        w_data_ok   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req || d_req) begin
                    w_owner_nxt = w_grant;
                    w_state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (!w_owner_req) begin
                    w_state_nxt = IDLE;
                end else if (m_addr_ok) begin
                    w_addr_ok = 1'b1;
                    if (m_data_ok) begin
                        w_data_ok   = 1'b1;
                        w_done      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (m_data_ok) begin
                    w_data_ok   = 1'b1;
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Forward the owner's fields live; zero whenever nothing is forwarded.
    always_comb begin
        m_req   = w_fwd;
        m_wr    = 1'b0;
        m_size  = 2'b00;
        m_addr  = '0;
        m_wdata = '0;
        if (w_fwd) begin
            m_wr    = r_owner ? d_wr    : i_wr;
            m_size  = r_owner ? d_size  : i_size;
            m_addr  = r_owner ? d_addr  : i_addr;
            m_wdata = r_owner ? d_wdata : i_wdata;
        end
    end

    assign i_addr_ok = w_addr_ok && !r_owner;
    assign i_data_ok = w_data_ok && !r_owner;
    assign d_addr_ok = w_addr_ok &&  r_owner;
    assign d_data_ok = w_data_ok &&  r_owner;
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

endmodule
